rob_complete_arbiter: RTL

//  Sole owner of the ROB completion write port; shares it between three completion sources:
//  src0 = ALU result (EX/MEM stage), src1 = load data (MEM/WB), src2 = multiply unit.

---
 rtl/rob_complete_arbiter_if.sv | 33 +++
 rtl/rob_complete_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rob_complete_arbiter_if.sv
// rob_complete_arbiter_if: completion-source bus into the ROB completion arbiter
// and the registered ROB write port coming back out.
// The master side drives the three completion sources and flush.
// The slave side (the arbiter) drives the ROB write, the full flags and the status outputs.
interface rob_complete_arbiter_if #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32
);
  logic                  in_flush;
  logic [2:0]            in_complete;
  logic [3*IDX_W-1:0]    in_complete_idx;
  logic [3*DATA_W-1:0]   in_complete_value;
  logic [8:0]            in_exception_vector;
  logic [2:0]            out_full;
  logic                  out_complete;
  logic [IDX_W-1:0]      out_complete_idx;
  logic [DATA_W-1:0]     out_complete_value;
  logic [2:0]            out_exception_vector;
  logic                  out_overflow;
  logic [15:0]           out_conflict_count;

  modport master (
    output in_flush, in_complete, in_complete_idx, in_complete_value, in_exception_vector,
    input  out_full, out_complete, out_complete_idx, out_complete_value,
           out_exception_vector, out_overflow, out_conflict_count
  );

  modport slave (
    input  in_flush, in_complete, in_complete_idx, in_complete_value, in_exception_vector,
    output out_full, out_complete, out_complete_idx, out_complete_value,
           out_exception_vector, out_overflow, out_conflict_count
  );
endinterface

// File: rtl/rob_complete_arbiter.sv
// rob_complete_arbiter: owns the ROB completion write port. Three completion
// sources (ALU, load, multiply) each feed a small FIFO. A round-robin arbiter
// picks one FIFO head per cycle, and the pick goes out through a registered port.
// Optional feature macro: ROB_ARB_PERF_EN builds the conflict perf counter.
// When the macro is not defined, out_conflict_count is tied to zero.
module rob_complete_arbiter #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input logic                  clk,
  input logic                  reset,
  rob_complete_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // FIFO storage and pointers, one set per source
  logic [IDX_W-1:0]  idx_mem_q [3][DEPTH];
  logic [DATA_W-1:0] val_mem_q [3][DEPTH];
  logic [2:0]        exc_mem_q [3][DEPTH];
  logic [PTR_W-1:0]  wptr_q [3];
  logic [PTR_W-1:0]  wptr_d [3];
  logic [PTR_W-1:0]  rptr_q [3];
  logic [PTR_W-1:0]  rptr_d [3];
  logic [CNT_W-1:0]  cnt_q [3];
  logic [CNT_W-1:0]  cnt_d [3];
  logic [2:0]        full_q, full_d;
  logic [1:0]        rr_q, rr_d;

  // Registered ROB port and sticky status
  logic              out_complete_q, out_complete_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_val_q, out_val_d;
  logic [2:0]        out_exc_q, out_exc_d;
  logic              ovf_q, ovf_d;

  logic [2:0]        nonempty_s;
  logic [2:0]        push_s;
  logic [2:0]        pop_s;
  logic              grant_valid_s;
  logic [1:0]        grant_s;

  // Candidates are the non-empty FIFOs; search starts at rr_q and wraps mod 3
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      nonempty_s[s] = (cnt_q[s] != {CNT_W{1'b0}});
    end
    grant_valid_s = |nonempty_s;
    grant_s       = 2'd0;
    case (rr_q)
      2'd1:    grant_s = nonempty_s[1] ? 2'd1 : (nonempty_s[2] ? 2'd2 : 2'd0);
      2'd2:    grant_s = nonempty_s[2] ? 2'd2 : (nonempty_s[0] ? 2'd0 : 2'd1);
      default: grant_s = nonempty_s[0] ? 2'd0 : (nonempty_s[1] ? 2'd1 : 2'd2);
    endcase
  end

  // FIFO push/pop bookkeeping; full is judged on the pre-pop count, and flush wins over everything
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      push_s[s] = bus.in_complete[s] && !full_q[s];
      pop_s[s]  = grant_valid_s && (grant_s == 2'(s));
      if (bus.in_flush) begin
        wptr_d[s] = {PTR_W{1'b0}};
        rptr_d[s] = {PTR_W{1'b0}};
        cnt_d[s]  = {CNT_W{1'b0}};
      end else begin
        wptr_d[s] = wptr_q[s] + PTR_W'(push_s[s]);
        rptr_d[s] = rptr_q[s] + PTR_W'(pop_s[s]);
        cnt_d[s]  = cnt_q[s] + CNT_W'(push_s[s]) - CNT_W'(pop_s[s]);
      end
      full_d[s] = (cnt_d[s] == CNT_FULL);
    end
    ovf_d = ovf_q | (|(bus.in_complete & full_q));
  end

  // Output register next state: the winner's head, or hold the data when there is no grant
  always_comb begin
    out_complete_d = 1'b0;
    out_idx_d      = out_idx_q;
    out_val_d      = out_val_q;
    out_exc_d      = out_exc_q;
    rr_d           = rr_q;
    if (bus.in_flush) begin
      out_complete_d = 1'b0;
      rr_d           = 2'd0;
    end else if (grant_valid_s) begin
      out_complete_d = 1'b1;
      out_idx_d      = idx_mem_q[grant_s][rptr_q[grant_s]];
      out_val_d      = val_mem_q[grant_s][rptr_q[grant_s]];
      out_exc_d      = exc_mem_q[grant_s][rptr_q[grant_s]];
      rr_d           = (grant_s == 2'd2) ? 2'd0 : (grant_s + 2'd1);
    end else begin
      out_complete_d = 1'b0;
      rr_d           = rr_q;
    end
  end

  // State registers: pointers, counts, flags and the ROB port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 3; s++) begin
        wptr_q[s] <= {PTR_W{1'b0}};
        rptr_q[s] <= {PTR_W{1'b0}};
        cnt_q[s]  <= {CNT_W{1'b0}};
      end
      full_q         <= 3'b000;
      rr_q           <= 2'd0;
      out_complete_q <= 1'b0;
      out_idx_q      <= {IDX_W{1'b0}};
      out_val_q      <= {DATA_W{1'b0}};
      out_exc_q      <= 3'b000;
      ovf_q          <= 1'b0;
    end else begin
      for (int s = 0; s < 3; s++) begin
        wptr_q[s] <= wptr_d[s];
        rptr_q[s] <= rptr_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
      full_q         <= full_d;
      rr_q           <= rr_d;
      out_complete_q <= out_complete_d;
      out_idx_q      <= out_idx_d;
      out_val_q      <= out_val_d;
      out_exc_q      <= out_exc_d;
      ovf_q          <= ovf_d;
    end
  end

  // FIFO storage write; a flushed cycle discards its pushes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 3; s++) begin
        for (int e = 0; e < DEPTH; e++) begin
          idx_mem_q[s][e] <= {IDX_W{1'b0}};
          val_mem_q[s][e] <= {DATA_W{1'b0}};
          exc_mem_q[s][e] <= 3'b000;
        end
      end
    end else begin
      for (int s = 0; s < 3; s++) begin
        if (push_s[s] && !bus.in_flush) begin
          idx_mem_q[s][wptr_q[s]] <= bus.in_complete_idx[s*IDX_W +: IDX_W];
          val_mem_q[s][wptr_q[s]] <= bus.in_complete_value[s*DATA_W +: DATA_W];
          exc_mem_q[s][wptr_q[s]] <= bus.in_exception_vector[s*3 +: 3];
        end
      end
    end
  end

`ifdef ROB_ARB_PERF_EN
  logic [15:0] conf_q, conf_d;
  logic        multi_s;

  // Count cycles with two or more sources waiting; saturate, never cleared by flush
  always_comb begin
    multi_s = (nonempty_s[0] & nonempty_s[1]) | (nonempty_s[0] & nonempty_s[2]) |
              (nonempty_s[1] & nonempty_s[2]);
    if (!bus.in_flush && multi_s && (conf_q != 16'hFFFF)) begin
      conf_d = conf_q + 16'd1;
    end else begin
      conf_d = conf_q;
    end
  end

  // Conflict counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conf_q <= 16'h0000;
    end else begin
      conf_q <= conf_d;
    end
  end

  assign bus.out_conflict_count = conf_q;
`else
  assign bus.out_conflict_count = 16'h0000;
`endif

  assign bus.out_full             = full_q;
  assign bus.out_complete         = out_complete_q;
  assign bus.out_complete_idx     = out_idx_q;
  assign bus.out_complete_value   = out_val_q;
  assign bus.out_exception_vector = out_exc_q;
  assign bus.out_overflow         = ovf_q;
endmodule
